// File: rtl/hatch_ctrl.sv
// Egg-hatching incubation controller: one-second time base, warm/cold second counters and game FSM.
// Outputs registered; st acts 3 cycles after the pin rises; no backpressure (free-running inputs).
module hatch_ctrl #(
   parameter int TICK_DIV   = 1000,
   parameter int STEP_SEC   = 2,
   parameter int COLD_LIMIT = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       st,
   input  logic       dst,
   output logic [4:0] dz_num,
   output logic       fail,
   output logic       hatched,
   output logic [3:0] cold_sec,
   output logic [1:0] state
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int WW = (STEP_SEC > 1) ? $clog2(STEP_SEC) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_INCUBATE = 2'b01,
      S_HATCHED  = 2'b10,
      S_FAIL     = 2'b11
   } state_t;

   state_t          cur;
   logic [TW-1:0]   tick_cnt;
   logic [WW-1:0]   warm_cnt;
   logic            st_s1, st_s2, st_d;
   logic            dst_s1, dst_s2;
   logic            st_rise;
   logic            tick;
   logic [3:0]      cold_nxt;

   assign state    = cur;
   assign st_rise  = st_s2 & ~st_d;
   assign tick     = (cur == S_INCUBATE) && (tick_cnt == TW'(TICK_DIV - 1));
   assign cold_nxt = cold_sec + 4'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur      <= S_IDLE;
         tick_cnt <= '0;
         warm_cnt <= '0;
         dz_num   <= 5'd0;
         cold_sec <= 4'd0;
         fail     <= 1'b0;
         hatched  <= 1'b0;
         st_s1    <= 1'b0;
         st_s2    <= 1'b0;
         st_d     <= 1'b0;
         dst_s1   <= 1'b0;
         dst_s2   <= 1'b0;
      end else begin
         st_s1  <= st;
         st_s2  <= st_s1;
         st_d   <= st_s2;
         dst_s1 <= dst;
         dst_s2 <= dst_s1;

         case (cur)
            S_IDLE: begin
               tick_cnt <= '0;
               if (st_rise) begin
                  cur      <= S_INCUBATE;
                  warm_cnt <= '0;
                  dz_num   <= 5'd0;
                  cold_sec <= 4'd0;
                  fail     <= 1'b0;
                  hatched  <= 1'b0;
               end
            end

            // st_rise is deliberately ignored here, even when it lands on a tick
            S_INCUBATE: begin
               if (tick) begin
                  tick_cnt <= '0;
                  if (dst_s2) begin
                     cold_sec <= 4'd0;
                     if (warm_cnt == WW'(STEP_SEC - 1)) begin
                        warm_cnt <= '0;
                        dz_num   <= dz_num + 5'd1;
                        if (dz_num == 5'd15) begin
                           cur     <= S_HATCHED;
                           hatched <= 1'b1;
                        end
                     end else begin
                        warm_cnt <= warm_cnt + WW'(1);
                     end
                  end else begin
                     // warm_cnt holds so a cold spell pauses progress rather than losing it
                     cold_sec <= cold_nxt;
                     if (cold_nxt == 4'(COLD_LIMIT)) begin
                        cur  <= S_FAIL;
                        fail <= 1'b1;
                     end
                  end
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
            end

            S_HATCHED, S_FAIL: begin
               tick_cnt <= '0;
               if (st_rise) begin
                  cur      <= S_IDLE;
                  warm_cnt <= '0;
                  dz_num   <= 5'd0;
                  cold_sec <= 4'd0;
                  fail     <= 1'b0;
                  hatched  <= 1'b0;
               end
            end

            default: cur <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hatch_ctrl.sv
// Directed bench for hatch_ctrl with TICK_DIV=4, STEP_SEC=2, COLD_LIMIT=3.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_hatch_ctrl;

   logic       clk;
   logic       rst;
   logic       st;
   logic       dst;
   logic [4:0] dz_num;
   logic       fail;
   logic       hatched;
   logic [3:0] cold_sec;
   logic [1:0] state;

   int checks = 0;
   int passes = 0;

   hatch_ctrl #(.TICK_DIV(4), .STEP_SEC(2), .COLD_LIMIT(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .st       (st),
      .dst      (dst),
      .dz_num   (dz_num),
      .fail     (fail),
      .hatched  (hatched),
      .cold_sec (cold_sec),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {state, dz_num, fail, hatched, cold_sec}
   logic [12:0] obs;
   assign obs = {state, dz_num, fail, hatched, cold_sec};

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   // Start from IDLE: state must still be IDLE after 2 edges and INCUBATE after the 3rd.
   task automatic start_game();
      st = 1'b1;
      step(1);
      st = 1'b0;
      step(1);
      checks++;
      if (state !== 2'b00) $display("FAIL start_latency_early state=%b want 00", state);
      else passes++;
      step(1);
      checks++;
      if (obs !== {2'b01, 5'd0, 1'b0, 1'b0, 4'd0})
         $display("FAIL start_entry obs=%b want %b", obs, {2'b01, 5'd0, 1'b0, 1'b0, 4'd0});
      else passes++;
   endtask

   task automatic test_reset();
      rst = 1'b1; st = 1'b1; dst = 1'b1;
      step(2);
      rst = 1'b0; st = 1'b0;
      checks++;
      if (obs !== 13'd0) $display("FAIL reset_state obs=%b want %b", obs, 13'd0);
      else passes++;
      step(20);
      checks++;
      if (obs !== 13'd0) $display("FAIL idle_no_progress obs=%b want %b", obs, 13'd0);
      else passes++;
   endtask

   task automatic test_warm_hatch();
      dst = 1'b1;
      start_game();
      step(7);
      checks++;
      if (dz_num !== 5'd0) $display("FAIL warm_before_first_step dz=%0d want 0", dz_num);
      else passes++;
      step(1);
      checks++;
      if (dz_num !== 5'd1) $display("FAIL warm_first_step dz=%0d want 1", dz_num);
      else passes++;
      for (int k = 2; k <= 15; k++) begin
         step(8);
         checks++;
         if (dz_num !== 5'(k)) $display("FAIL warm_step_%0d dz=%0d want %0d", k, dz_num, k);
         else passes++;
      end
      step(7);
      checks++;
      if (obs !== {2'b01, 5'd15, 1'b0, 1'b0, 4'd0})
         $display("FAIL hatch_cycle_127 obs=%b want %b", obs, {2'b01, 5'd15, 1'b0, 1'b0, 4'd0});
      else passes++;
      step(1);
      checks++;
      if (obs !== {2'b10, 5'd16, 1'b0, 1'b1, 4'd0})
         $display("FAIL hatch_cycle_128 obs=%b want %b", obs, {2'b10, 5'd16, 1'b0, 1'b1, 4'd0});
      else passes++;
      dst = 1'b0;
      step(50);
      checks++;
      if (obs !== {2'b10, 5'd16, 1'b0, 1'b1, 4'd0})
         $display("FAIL hatch_hold obs=%b want %b", obs, {2'b10, 5'd16, 1'b0, 1'b1, 4'd0});
      else passes++;
      st = 1'b1;
      step(1);
      st = 1'b0;
      step(2);
      checks++;
      if (obs !== 13'd0) $display("FAIL hatch_to_idle obs=%b want %b", obs, 13'd0);
      else passes++;
   endtask

   task automatic test_cold_interrupt();
      do_reset();
      dst = 1'b1;
      start_game();
      step(4);
      checks++;
      if (obs !== {2'b01, 5'd0, 1'b0, 1'b0, 4'd0})
         $display("FAIL intr_warm1 obs=%b want %b", obs, {2'b01, 5'd0, 1'b0, 1'b0, 4'd0});
      else passes++;
      dst = 1'b0;
      step(4);
      checks++;
      if (cold_sec !== 4'd1) $display("FAIL intr_cold1 cold_sec=%0d want 1", cold_sec);
      else passes++;
      step(4);
      checks++;
      if (obs !== {2'b01, 5'd0, 1'b0, 1'b0, 4'd2})
         $display("FAIL intr_cold2 obs=%b want %b", obs, {2'b01, 5'd0, 1'b0, 1'b0, 4'd2});
      else passes++;
      dst = 1'b1;
      step(4);
      checks++;
      if (obs !== {2'b01, 5'd1, 1'b0, 1'b0, 4'd0})
         $display("FAIL intr_warm2 obs=%b want %b", obs, {2'b01, 5'd1, 1'b0, 1'b0, 4'd0});
      else passes++;
   endtask

   task automatic test_mid_reset();
      do_reset();
      dst = 1'b1;
      start_game();
      step(40);
      checks++;
      if (dz_num !== 5'd5) $display("FAIL midrst_dz5 dz=%0d want 5", dz_num);
      else passes++;
      step(2);
      rst = 1'b1; st = 1'b1;
      step(1);
      rst = 1'b0; st = 1'b0;
      checks++;
      if (obs !== 13'd0) $display("FAIL midrst_idle obs=%b want %b", obs, 13'd0);
      else passes++;
      step(10);
      checks++;
      if (obs !== 13'd0) $display("FAIL midrst_st_ignored obs=%b want %b", obs, 13'd0);
      else passes++;
   endtask

   task automatic test_cold_fail();
      dst = 1'b1;
      start_game();
      step(12);
      checks++;
      if (obs !== {2'b01, 5'd1, 1'b0, 1'b0, 4'd0})
         $display("FAIL cold_warmup obs=%b want %b", obs, {2'b01, 5'd1, 1'b0, 1'b0, 4'd0});
      else passes++;
      dst = 1'b0;
      step(4);
      checks++;
      if (cold_sec !== 4'd1) $display("FAIL cold_sec1 cold_sec=%0d want 1", cold_sec);
      else passes++;
      step(4);
      checks++;
      if (cold_sec !== 4'd2) $display("FAIL cold_sec2 cold_sec=%0d want 2", cold_sec);
      else passes++;
      step(3);
      checks++;
      if (obs !== {2'b01, 5'd1, 1'b0, 1'b0, 4'd2})
         $display("FAIL cold_before_fail obs=%b want %b", obs, {2'b01, 5'd1, 1'b0, 1'b0, 4'd2});
      else passes++;
      step(1);
      checks++;
      if (obs !== {2'b11, 5'd1, 1'b1, 1'b0, 4'd3})
         $display("FAIL cold_fail obs=%b want %b", obs, {2'b11, 5'd1, 1'b1, 1'b0, 4'd3});
      else passes++;
      dst = 1'b1;
      step(20);
      checks++;
      if (obs !== {2'b11, 5'd1, 1'b1, 1'b0, 4'd3})
         $display("FAIL fail_frozen obs=%b want %b", obs, {2'b11, 5'd1, 1'b1, 1'b0, 4'd3});
      else passes++;
   endtask

   task automatic test_restart();
      st = 1'b1;
      step(1);
      st = 1'b0;
      step(2);
      checks++;
      if (obs !== 13'd0) $display("FAIL restart_idle obs=%b want %b", obs, 13'd0);
      else passes++;
      dst = 1'b0;
      start_game();
      step(3);
      checks++;
      if (obs !== {2'b01, 5'd0, 1'b0, 1'b0, 4'd0})
         $display("FAIL restart_pre_tick obs=%b want %b", obs, {2'b01, 5'd0, 1'b0, 1'b0, 4'd0});
      else passes++;
      step(1);
      checks++;
      if (cold_sec !== 4'd1) $display("FAIL restart_first_tick cold_sec=%0d want 1", cold_sec);
      else passes++;
   endtask

   initial begin
      rst = 1'b1;
      st  = 1'b0;
      dst = 1'b0;
      test_reset();
      test_warm_hatch();
      test_cold_interrupt();
      test_mid_reset();
      test_cold_fail();
      test_restart();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
